// File: rtl/rtr_pkt_serializer_if.sv
// Upstream packet handshake bundle for rtr_pkt_serializer.
// The feeder drives valid/addr/data through the master modport. The serializer
// returns ready through the slave modport.
interface rtr_pkt_serializer_if;
    logic       pkt_valid;
    logic [1:0] pkt_addr;
    logic [3:0] pkt_data;
    logic       pkt_ready;

    modport master (
        output pkt_valid,
        output pkt_addr,
        output pkt_data,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid,
        input  pkt_addr,
        input  pkt_data,
        output pkt_ready
    );
endinterface

// File: rtl/rtr_pkt_serializer.sv
// rtr_pkt_serializer: parallel packet FIFO feeding the 4-port serial router.
// Each 6-bit word {addr, data} leaves MSB first on ser_out while ser_en is high.
// ser_en stays high for exactly 6 cycles. Bursts are followed by GAP_CYCLES idle
// cycles, which give the router time to commit each packet.
// Optional build macro SER_STATS_EN adds the pkt_sent_cnt and stall_cnt counters.
module rtr_pkt_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    rtr_pkt_serializer_if.slave           up,
    output logic                          ser_out,
    output logic                          ser_en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef SER_STATS_EN
    ,
    output logic [15:0]                   pkt_sent_cnt,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [5:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [5:0]    shreg_r;
    logic [5:0]    shreg_nxt_s;
    logic [2:0]    bit_cnt_r;
    logic [2:0]    bit_cnt_nxt_s;
    logic [GW-1:0] gap_cnt_r;
    logic [GW-1:0] gap_cnt_nxt_s;
    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          ser_out_r;
    logic          ser_en_r;
    logic          busy_r;

    assign ready_s      = (count_r != CW'(FIFO_DEPTH));
    assign push_s       = up.pkt_valid && ready_s;
    assign up.pkt_ready = ready_s;
    assign fifo_count   = count_r;
    assign ser_out      = ser_out_r;
    assign ser_en       = ser_en_r;
    assign busy         = busy_r;

    // Burst sequencer: pops a word when idle or at the end of a gap, then shifts it out.
    always_comb begin
        state_nxt_s   = state_r;
        shreg_nxt_s   = shreg_r;
        bit_cnt_nxt_s = bit_cnt_r;
        gap_cnt_nxt_s = gap_cnt_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != {CW{1'b0}}) begin
                    pop_s         = 1'b1;
                    shreg_nxt_s   = mem_r[rd_ptr_r];
                    bit_cnt_nxt_s = 3'd0;
                    state_nxt_s   = ST_SHIFT;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_nxt_s = {shreg_r[4:0], 1'b0};
                if (bit_cnt_r == 3'd5) begin
                    bit_cnt_nxt_s = 3'd0;
                    gap_cnt_nxt_s = {GW{1'b0}};
                    state_nxt_s   = ST_GAP;
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GW'(GAP_CYCLES - 1)) begin
                    if (count_r != {CW{1'b0}}) begin
                        pop_s         = 1'b1;
                        shreg_nxt_s   = mem_r[rd_ptr_r];
                        bit_cnt_nxt_s = 3'd0;
                        state_nxt_s   = ST_SHIFT;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                    end
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Packet storage; no reset needed because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {up.pkt_addr, up.pkt_data};
        end
    end

    // FIFO pointers, count and sequencer state; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            state_r   <= ST_IDLE;
            shreg_r   <= 6'd0;
            bit_cnt_r <= 3'd0;
            gap_cnt_r <= {GW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r   <= count_nxt_s;
            state_r   <= state_nxt_s;
            shreg_r   <= shreg_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
        end
    end

    // Registered serial outputs trail the sequencer by one cycle; busy tracks next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_out_r <= 1'b0;
            ser_en_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            ser_en_r  <= (state_r == ST_SHIFT);
            ser_out_r <= (state_r == ST_SHIFT) ? shreg_r[5] : 1'b0;
            busy_r    <= (state_nxt_s != ST_IDLE) || (count_nxt_s != {CW{1'b0}});
        end
    end

`ifdef SER_STATS_EN
    // Statistics: completed bursts (wrapping) and refused offers (saturating).
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_sent_cnt <= 16'd0;
            stall_cnt    <= 16'd0;
        end else begin
            if ((state_r == ST_SHIFT) && (bit_cnt_r == 3'd5)) begin
                pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
            end
            if (up.pkt_valid && !ready_s && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
